// File: rtl/traffic_gen_if.sv
// traffic_gen_if: op/operand bus from the op sequencer and the flit/done
// outputs of one traffic_gen.
//   op     [2:0]     command (NOP/Init/Fill/Dequeue)
//   data   [DATA_W]  operand: Init total in LSBs, Fill {dst, vc, numflit}
//   done             all announced packets filled and fully dequeued
//   buffer [BUF_W]   current flit {seq, dst, vc, tail, head, valid}
// master = op sequencer side, slave = traffic_gen side.
interface traffic_gen_if #(
  parameter int unsigned DST_W   = 8,
  parameter int unsigned VC_W    = 2,
  parameter int unsigned NFLIT_W = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned DATA_W = CNT_W + DST_W + VC_W + NFLIT_W;
  localparam int unsigned BUF_W  = 3 + VC_W + DST_W + NFLIT_W;

  logic [2:0]        op;
  logic [DATA_W-1:0] data;
  logic              done;
  logic [BUF_W-1:0]  buffer;

  modport master (output op, output data, input done, input buffer);
  modport slave  (input op, input data, output done, output buffer);
endinterface

// File: rtl/traffic_gen.sv
// traffic_gen: per-router packet source. Init announces a packet count,
// Fill queues descriptors {dst, vc, numflit}, and each Dequeue advances the
// presented flit; a descriptor is popped when its tail flit is dequeued.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  traffic_gen_if.slave (op, data in; done, buffer out, both registered)
// Optional: define TRAFFIC_DEBUG_EN for simulation-only error/op logging.
module traffic_gen #(
  parameter int unsigned DST_W   = 8,
  parameter int unsigned VC_W    = 2,
  parameter int unsigned NFLIT_W = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BUF_W   = 3 + VC_W + DST_W + NFLIT_W
) (
  input  logic          clk,
  input  logic          rst,
  traffic_gen_if.slave  bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned DESC_W = DST_W + VC_W + NFLIT_W;
  localparam int unsigned DATA_W = CNT_W + DESC_W;

  localparam logic [2:0] OP_INIT = 3'd1;
  localparam logic [2:0] OP_FILL = 3'd2;
  localparam logic [2:0] OP_DEQ  = 3'd3;

  logic [DESC_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [NFLIT_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0]   total, total_nxt, filled, filled_nxt;
  logic               initd, initd_nxt;
  logic [BUF_W-1:0]   buffer_q, buffer_nxt;
  logic               done_q, done_nxt;
  logic               push, empty, full, empty_nxt;
  logic [DESC_W-1:0]  fill_desc, head_desc, head_nxt;
  logic               unused_data;

  // Index of the last flit; numflit==0 is a 1-flit packet
  function automatic logic [NFLIT_W-1:0] last_idx(input logic [DESC_W-1:0] d);
    logic [NFLIT_W-1:0] nf;
    nf = d[NFLIT_W-1:0];
    return (nf == '0) ? '0 : nf - NFLIT_W'(1);
  endfunction

  // Flit word for descriptor d at index i
  function automatic logic [BUF_W-1:0] make_flit(input logic [DESC_W-1:0] d,
                                                 input logic [NFLIT_W-1:0] i);
    return {i, d[DESC_W-1:VC_W+NFLIT_W], d[VC_W+NFLIT_W-1:NFLIT_W],
            i == last_idx(d), i == '0, 1'b1};
  endfunction

  assign unused_data = ^bus.data[DATA_W-1:DESC_W];
  assign fill_desc   = bus.data[DESC_W-1:0];
  assign head_desc   = mem[rd_ptr[AW-1:0]];
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Next-state and next registered outputs
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    idx_nxt    = idx;
    total_nxt  = total;
    filled_nxt = filled;
    initd_nxt  = initd;
    push       = 1'b0;
    case (bus.op)
      OP_INIT: begin
        wr_ptr_nxt = '0;
        rd_ptr_nxt = '0;
        idx_nxt    = '0;
        total_nxt  = bus.data[CNT_W-1:0];
        filled_nxt = '0;
        initd_nxt  = 1'b1;
      end
      OP_FILL: begin
        if (initd && (filled != total) && !full) begin
          push       = 1'b1;
          wr_ptr_nxt = wr_ptr + (AW+1)'(1);
          filled_nxt = filled + CNT_W'(1);
        end
      end
      OP_DEQ: begin
        if (buffer_q[0]) begin
          if (idx == last_idx(head_desc)) begin
            idx_nxt    = '0;
            rd_ptr_nxt = rd_ptr + (AW+1)'(1);
          end else begin
            idx_nxt = idx + NFLIT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A push into an empty queue becomes the head in the same edge
    head_nxt   = (push && empty) ? fill_desc : mem[rd_ptr_nxt[AW-1:0]];
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    buffer_nxt = empty_nxt ? '0 : make_flit(head_nxt, idx_nxt);
    done_nxt   = initd_nxt && (filled_nxt == total_nxt) && empty_nxt;
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      total    <= '0;
      filled   <= '0;
      initd    <= 1'b0;
      buffer_q <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      idx      <= idx_nxt;
      total    <= total_nxt;
      filled   <= filled_nxt;
      initd    <= initd_nxt;
      buffer_q <= buffer_nxt;
      done_q   <= done_nxt;
    end
  end

  // Descriptor storage
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr[AW-1:0]] <= fill_desc;
  end

  assign bus.buffer = buffer_q;
  assign bus.done   = done_q;

`ifdef TRAFFIC_DEBUG_EN
  // Simulation-only diagnostics
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (bus.op)
        OP_INIT: $display("%0t %m: init total=%0d", $time, bus.data[CNT_W-1:0]);
        OP_FILL: begin
          if (!initd)             $display("%0t %m: ERROR fill before init", $time);
          else if (filled == total) $display("%0t %m: ERROR fill beyond total", $time);
          else if (full)          $display("%0t %m: ERROR fill to full queue", $time);
          else                    $display("%0t %m: fill desc=%h", $time, fill_desc);
        end
        OP_DEQ: begin
          if (!buffer_q[0]) $display("%0t %m: ERROR dequeue with no valid flit", $time);
          else              $display("%0t %m: dequeue flit=%h", $time, buffer_q);
        end
        default: ;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_traffic_gen.sv
// Scoreboard bench for traffic_gen: the driver updates a packet-level model
// and pushes expected flits; the negedge monitor compares buffer/done.
module tb_traffic_gen;
  localparam int unsigned DST_W   = 8;
  localparam int unsigned VC_W    = 2;
  localparam int unsigned NFLIT_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DATA_W  = CNT_W + DST_W + VC_W + NFLIT_W;
  localparam int unsigned BUF_W   = 3 + VC_W + DST_W + NFLIT_W;

  logic clk;
  logic rst;
  traffic_gen_if #(.DST_W(DST_W), .VC_W(VC_W), .NFLIT_W(NFLIT_W), .CNT_W(CNT_W)) bus();

  traffic_gen #(.DST_W(DST_W), .VC_W(VC_W), .NFLIT_W(NFLIT_W), .CNT_W(CNT_W),
                .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [BUF_W-1:0] exp_flits[$];
  bit               m_initd;
  int unsigned      m_total, m_filled;
  bit               mon_en;
  int unsigned      checks, errors;

  function automatic int unsigned pkts_queued();
    int unsigned n = 0;
    foreach (exp_flits[i]) if (exp_flits[i][2]) n++;
    return n;
  endfunction

  task automatic commit(input logic r, input logic [2:0] o, input logic [DATA_W-1:0] d);
    int unsigned n;
    logic [NFLIT_W-1:0] nf;
    logic [VC_W-1:0]    vc;
    logic [DST_W-1:0]   dst;
    if (r) begin
      m_initd = 0; m_total = 0; m_filled = 0; exp_flits.delete();
    end else begin
      case (o)
        3'd1: begin
          m_initd = 1; m_total = int'(d[CNT_W-1:0]); m_filled = 0; exp_flits.delete();
        end
        3'd2: begin
          if (m_initd && m_filled < m_total && pkts_queued() < DEPTH) begin
            nf  = d[NFLIT_W-1:0];
            vc  = d[NFLIT_W+VC_W-1:NFLIT_W];
            dst = d[NFLIT_W+VC_W+DST_W-1:NFLIT_W+VC_W];
            n   = (nf == 0) ? 1 : int'(nf);
            for (int s = 0; s < int'(n); s++)
              exp_flits.push_back({NFLIT_W'(s), dst, vc, s == int'(n) - 1, s == 0, 1'b1});
            m_filled++;
          end
        end
        3'd3: if (exp_flits.size() > 0) void'(exp_flits.pop_front());
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic [DATA_W-1:0] d);
    rst = r; bus.op = o; bus.data = d;
    @(posedge clk); #1;
    commit(r, o, d);
  endtask

  task automatic fill(input int dst, input int vc, input int nf);
    step(1'b0, 3'd2, {CNT_W'(0), DST_W'(dst), VC_W'(vc), NFLIT_W'(nf)});
  endtask

  task automatic init(input int total);
    step(1'b0, 3'd1, DATA_W'(total));
  endtask

  // Monitor: compare presented flit and done against the model
  always @(negedge clk) begin
    if (mon_en) begin
      logic [BUF_W-1:0] e_buf;
      logic             e_done;
      e_buf  = (exp_flits.size() > 0) ? exp_flits[0] : '0;
      e_done = m_initd && (m_filled == m_total) && (exp_flits.size() == 0);
      checks++;
      if (bus.buffer !== e_buf) begin
        errors++;
        $display("FAIL buffer got %h exp %h at %0t", bus.buffer, e_buf, $time);
      end
      checks++;
      if (bus.done !== e_done) begin
        errors++;
        $display("FAIL done got %b exp %b at %0t", bus.done, e_done, $time);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 0;
    m_initd = 0; m_total = 0; m_filled = 0;
    rst = 1'b1; bus.op = '0; bus.data = '0;
    step(1'b1, 3'd0, '0);
    step(1'b1, 3'd0, '0);
    mon_en = 1;
    step(1'b0, 3'd0, '0);
    step(1'b0, 3'd0, '0);

    // total = 0 gives done at once
    init(0);
    step(1'b0, 3'd0, '0);

    // 3-flit packet
    init(1);
    fill(5, 1, 3);
    step(1'b0, 3'd0, '0);
    repeat (3) step(1'b0, 3'd3, '0);
    step(1'b0, 3'd0, '0);

    // back-to-back 1-flit packets
    init(2);
    fill(3, 2, 1);
    fill(7, 3, 0);
    step(1'b0, 3'd3, '0);
    step(1'b0, 3'd3, '0);
    step(1'b0, 3'd0, '0);

    // queue full, drain, refill across the wrap
    init(DEPTH + 1);
    for (int i = 0; i < int'(DEPTH) + 1; i++) fill(16 + i, i % 4, (i % 2) + 1);
    repeat (14) step(1'b0, 3'd3, '0);
    fill(99, 2, 2);
    fill(100, 1, 1);
    repeat (3) step(1'b0, 3'd3, '0);

    // extra fill and dequeue on empty
    init(1);
    fill(1, 0, 1);
    fill(2, 0, 1);
    step(1'b0, 3'd3, '0);
    step(1'b0, 3'd3, '0);
    step(1'b0, 3'd2, '0);

    // abort mid-packet with Init, then with rst
    init(1);
    fill(9, 1, 4);
    step(1'b0, 3'd3, '0);
    init(1);
    fill(10, 2, 2);
    step(1'b0, 3'd3, '0);
    step(1'b0, 3'd3, '0);
    init(1);
    fill(11, 3, 4);
    step(1'b0, 3'd3, '0);
    step(1'b1, 3'd0, '0);
    step(1'b0, 3'd2, '0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 3'($urandom), DATA_W'($urandom));
      else if (r < 6)  step(1'b0, 3'd1, {(DATA_W-CNT_W)'($urandom), CNT_W'($urandom_range(0, 12))});
      else if (r < 10) step(1'b0, 3'($urandom_range(4, 7)), DATA_W'($urandom));
      else if (r < 18) step(1'b0, 3'd0, DATA_W'($urandom));
      else if (r < 52) step(1'b0, 3'd2, DATA_W'($urandom));
      else             step(1'b0, 3'd3, DATA_W'($urandom));
    end
    step(1'b0, 3'd0, '0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
